// File: rtl/max_stream.sv
`default_nettype none
// max_stream -- sequential argmax over a frame of NUM_CLASSES scores, valid/ready in and out.
// Rev 1.0
module max_stream #(
  parameter int NUM_SIZE    = 26,
  parameter int NUM_CLASSES = 10,
  parameter bit SIGNED      = 1'b0,
  parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                Clk,
  input  logic                GlobalReset,
  input  logic                Clear,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [NUM_SIZE-1:0] In_Data,
  input  logic                In_Last,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [IDX_W-1:0]    Out_Index,
  output logic [NUM_SIZE-1:0] Out_Max,
  output logic                Out_Error
);

  localparam logic [0:0]       ST_ACCUM   = 1'b0;
  localparam logic [0:0]       ST_DONE    = 1'b1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  logic [0:0]          r_state;
  logic [IDX_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_SIZE-1:0] r_max;
  logic                r_err;
  logic                w_greater;
  logic                w_at_last;
  logic                w_frame_end;

  generate
    if (SIGNED) begin : g_signed_cmp
      assign w_greater = $signed(In_Data) > $signed(r_max);
    end else begin : g_unsigned_cmp
      assign w_greater = In_Data > r_max;
    end
  endgenerate

  // Ready is masked by reset so nothing looks acceptable while reset is held.
  assign In_Ready    = (r_state == ST_ACCUM) & GlobalReset;
  assign Out_Valid   = (r_state == ST_DONE);
  assign w_at_last   = (r_cnt == c_LAST_IDX);
  assign w_frame_end = In_Last | w_at_last;

  assign Out_Index = r_idx;
  assign Out_Max   = r_max;
  assign Out_Error = r_err;

  always_ff @(posedge Clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_max   <= '0;
      r_err   <= 1'b0;
    end else if (Clear) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (r_state == ST_ACCUM) begin
      if (In_Valid) begin
        if (r_cnt == '0) begin
          r_max <= In_Data;
          r_idx <= '0;
          r_err <= 1'b0;
        end else if (w_greater) begin
          r_max <= In_Data;
          r_idx <= r_cnt;
        end
        // Error flags a disagreement between the Last marker and the expected length.
        if (w_frame_end) begin
          r_state <= ST_DONE;
          r_cnt   <= '0;
          r_err   <= In_Last ^ w_at_last;
        end else begin
          r_cnt <= r_cnt + IDX_W'(1);
        end
      end
    end else if (Out_Ready) begin
      r_state <= ST_ACCUM;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_stream.sv
`default_nettype none
// tb_max_stream -- randomized and directed checks of max_stream against a queue-based argmax model.
module tb_max_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [25:0] in_data = '0;

  logic        ir_m, ov_m, oe_m, ir_s, ov_s, oe_s, ir_u, ov_u, oe_u;
  logic [3:0]  idx_m, idx_s, idx_u;
  logic [25:0] max_m;
  logic [7:0]  max_s, max_u;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  max_stream #(.NUM_SIZE(26), .NUM_CLASSES(10), .SIGNED(1'b0)) dut_main (
    .Clk(clk), .GlobalReset(rst_n), .Clear(clear), .In_Valid(in_valid), .In_Ready(ir_m),
    .In_Data(in_data), .In_Last(in_last), .Out_Valid(ov_m), .Out_Ready(out_ready),
    .Out_Index(idx_m), .Out_Max(max_m), .Out_Error(oe_m));

  max_stream #(.NUM_SIZE(8), .NUM_CLASSES(10), .SIGNED(1'b1)) dut_s8 (
    .Clk(clk), .GlobalReset(rst_n), .Clear(clear), .In_Valid(in_valid), .In_Ready(ir_s),
    .In_Data(in_data[7:0]), .In_Last(in_last), .Out_Valid(ov_s), .Out_Ready(out_ready),
    .Out_Index(idx_s), .Out_Max(max_s), .Out_Error(oe_s));

  max_stream #(.NUM_SIZE(8), .NUM_CLASSES(10), .SIGNED(1'b0)) dut_u8 (
    .Clk(clk), .GlobalReset(rst_n), .Clear(clear), .In_Valid(in_valid), .In_Ready(ir_u),
    .In_Data(in_data[7:0]), .In_Last(in_last), .Out_Valid(ov_u), .Out_Ready(out_ready),
    .Out_Index(idx_u), .Out_Max(max_u), .Out_Error(oe_u));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model: collect the frame, argmax it at the end ----------------
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  logic [25:0] frame[$];
  int          e_idx[3];
  logic [25:0] e_max[3];

  function automatic void argmax(input int w, input bit sgn, output int idx, output logic [25:0] mx);
    longint mask = (longint'(1) << w) - 1;
    longint best = 0;
    idx = 0;
    mx  = '0;
    for (int i = 0; i < frame.size(); i++) begin
      longint v = longint'(frame[i]) & mask;
      longint key = (sgn && v[w-1]) ? v - (longint'(1) << w) : v;
      if (i == 0 || key > best) begin
        best = key;
        idx  = i;
        mx   = 26'(v);
      end
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || clear) begin
      m_done = 1'b0;
      m_err  = 1'b0;
      frame.delete();
    end else if (!m_done) begin
      if (in_valid) begin
        frame.push_back(in_data);
        if (in_last || frame.size() == 10) begin
          m_err = (in_last != (frame.size() == 10));
          argmax(26, 1'b0, e_idx[0], e_max[0]);
          argmax(8,  1'b1, e_idx[1], e_max[1]);
          argmax(8,  1'b0, e_idx[2], e_max[2]);
          m_done = 1'b1;
          frame.delete();
        end
      end
    end else if (out_ready) begin
      m_done = 1'b0;
    end
  end

  task automatic check_dut(input string nm, input int k, input logic irv, input logic ovv,
                           input logic [31:0] idx, input logic [31:0] mx, input logic er);
    if (!rst_n) begin
      chk({nm, "_rst_ready"}, irv, 0);
      chk({nm, "_rst_valid"}, ovv, 0);
      chk({nm, "_rst_index"}, idx, 0);
      chk({nm, "_rst_max"}, mx, 0);
      chk({nm, "_rst_error"}, er, 0);
    end else begin
      chk({nm, "_in_ready"}, irv, !m_done);
      chk({nm, "_out_valid"}, ovv, m_done);
      if (m_done) begin
        chk({nm, "_index"}, idx, e_idx[k]);
        chk({nm, "_max"}, mx, e_max[k]);
        chk({nm, "_error"}, er, m_err);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    check_dut("main", 0, ir_m, ov_m, 32'(idx_m), 32'(max_m), oe_m);
    check_dut("s8",   1, ir_s, ov_s, 32'(idx_s), 32'(max_s), oe_s);
    check_dut("u8",   2, ir_u, ov_u, 32'(idx_u), 32'(max_u), oe_u);
  end

  // ---------------- stimulus ----------------
  logic [25:0] sc[10];

  task automatic put(input logic [25:0] d, input bit last, input int gap);
    int t = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!ir_m) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        n_vec++;
        n_err++;
        $display("FAIL put_timeout: got no In_Ready, required In_Ready within 100 cycles");
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int n, input int last_pos, input int gap_max);
    for (int i = 0; i < n; i++)
      put(sc[i], i == last_pos, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic result(input string nm, input int idx, input logic [25:0] mx, input logic er);
    int t = 0;
    while (!ov_m && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_valid_seen"}, ov_m, 1);
    chk({nm, "_index"}, 32'(idx_m), idx);
    chk({nm, "_max"}, 32'(max_m), 32'(mx));
    chk({nm, "_error"}, oe_m, er);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("reset_in_ready", ir_m, 0);
    chk("reset_out_valid", ov_m, 0);
    chk("reset_index", 32'(idx_m), 0);
    chk("reset_max", 32'(max_m), 0);
    chk("reset_error", oe_m, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", ir_m, 1);

    // unsigned ordered frame, latency and back-pressure
    sc = '{26'd5, 26'd9, 26'd3, 26'd9, 26'd1, 26'd0, 26'd2, 26'd8, 26'd7, 26'd4};
    send(10, 9, 0);
    chk("ordered_latency", ov_m, 1);
    result("ordered", 1, 26'd9, 1'b0);
    in_valid = 1'b1;
    in_data  = 26'h3FFFFFF;
    repeat (5) begin
      chk("bp_in_ready", ir_m, 0);
      chk("bp_index", 32'(idx_m), 1);
      chk("bp_max", 32'(max_m), 9);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", ir_m, 1);
    chk("bp_release_valid", ov_m, 0);

    // signed vs unsigned comparison
    sc = '{26'hF0, 26'h80, 26'hFF, 26'hFE, 26'hFE, 26'hFE, 26'hFE, 26'hFE, 26'hFE, 26'hFE};
    send(10, 9, 0);
    result("sgn_main", 2, 26'hFF, 1'b0);
    chk("sgn_s8_index", 32'(idx_s), 2);
    chk("sgn_s8_max", 32'(max_s), 32'hFF);
    chk("sgn_u8_index", 32'(idx_u), 2);
    ack();
    sc[2] = 26'h7F;
    send(10, 9, 0);
    result("swap_main", 3, 26'hFE, 1'b0);
    chk("swap_s8_index", 32'(idx_s), 2);
    chk("swap_s8_max", 32'(max_s), 32'h7F);
    chk("swap_u8_index", 32'(idx_u), 3);
    chk("swap_u8_max", 32'(max_u), 32'hFE);
    ack();

    // early and missing Last
    sc = '{26'd1, 26'd7, 26'd2, 26'd5, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0};
    send(4, 3, 0);
    result("early_last", 1, 26'd7, 1'b1);
    ack();
    sc = '{26'd3, 26'd1, 26'd4, 26'd1, 26'd5, 26'd9, 26'd2, 26'd6, 26'd5, 26'd3};
    send(10, -1, 0);
    result("missing_last", 5, 26'd9, 1'b1);
    ack();

    // Clear mid-frame drops the concurrent score
    sc = '{26'd20, 26'd21, 26'd22, 26'd23, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0};
    send(4, -1, 0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 26'h3FFFFFF;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_in_ready", ir_m, 1);
    chk("clear_out_valid", ov_m, 0);
    sc = '{26'd5, 26'd9, 26'd3, 26'd9, 26'd1, 26'd0, 26'd2, 26'd8, 26'd7, 26'd4};
    send(10, 9, 0);
    result("after_clear", 1, 26'd9, 1'b0);
    ack();

    // reset mid-frame
    sc = '{26'd100, 26'd200, 26'd50, 26'd60, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0};
    send(4, -1, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_index", 32'(idx_m), 0);
    chk("midrst_max", 32'(max_m), 0);
    chk("midrst_valid", ov_m, 0);
    chk("midrst_ready", ir_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", ir_m, 1);
    chk("midrst_release_valid", ov_m, 0);

    // all-equal scores with gaps
    for (int i = 0; i < 10; i++) sc[i] = 26'h3FFFFFF;
    send(10, 9, 3);
    result("equal", 0, 26'h3FFFFFF, 1'b0);
    chk("equal_s8_index", 32'(idx_s), 0);
    chk("equal_s8_max", 32'(max_s), 32'hFF);
    ack();

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 26'($urandom);
      in_last   = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      clear     = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/max_stream.md
# max_stream

Sequential, parametrised argmax engine for the classifier output stage. Accepts a frame of `NUM_CLASSES` scores one per cycle over a valid/ready stream and tracks the running maximum. It presents the winning index, the winning value and a frame-error flag on a valid/ready result port. It generalises the fixed 10-input combinational argmax to any class count, with signed/unsigned comparison, back-pressure and frame-length checking.

## Interface
- `NUM_SIZE`, 26: width of each score in bits.
- `NUM_CLASSES`, 10: scores per frame; legal range 2..65536.
- `SIGNED`, 0: 1 = compare scores as two's complement; 0 = compare unsigned.
- `IDX_W`, `$clog2(NUM_CLASSES)`: width of the index and the element counter; minimum 1.

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `GlobalReset`  in  1  asynchronous, active-low reset.
- `Clear`  in  1  synchronous frame abort.
- `In_Valid`  in  1  score valid.
- `In_Ready`  out  1  engine can accept a score.
- `In_Data`  in  `NUM_SIZE`  score.
- `In_Last`  in  1  marks the final score of the frame.
- `Out_Valid`  out  1  result valid.
- `Out_Ready`  in  1  consumer accepts the result.
- `Out_Index`  out  `IDX_W`  index of the maximum score within the frame.
- `Out_Max`  out  `NUM_SIZE`  maximum score value.
- `Out_Error`  out  1  frame length did not match `NUM_CLASSES`.

## Operation
- States: ACCUM and DONE.
  - `In_Ready` = (state == ACCUM).
  - `Out_Valid` = (state == DONE).
- Reset (`GlobalReset` = 0), applied asynchronously:
  - state = ACCUM, counter = 0.
  - `Out_Index` = 0, `Out_Max` = 0, `Out_Error` = 0, `Out_Valid` = 0.
  - `In_Ready` is forced to 0 while reset is held, and becomes 1 on the first cycle after release.
- Score handshake: a score is accepted when `In_Valid` & `In_Ready`.
- Element at counter 0: loads `Out_Max` = `In_Data` and `Out_Index` = 0 unconditionally, and clears the error accumulator.
- Element at counter k > 0: replaces the running max only if `In_Data` is strictly greater than `Out_Max`, then sets `Out_Index` = k.
  - Comparison is signed when `SIGNED` = 1 and unsigned otherwise.
  - Ties therefore keep the lowest index.
- End of frame: the frame ends on the first accepted element that satisfies either condition below. The state then moves to DONE and the counter resets to 0.
  - `In_Last` = 1, or
  - counter == `NUM_CLASSES`-1.
- `Out_Error` at end of frame is 1 if the two conditions disagree:
  - early last: `In_Last` = 1 with counter < `NUM_CLASSES`-1. The result covers only the received elements.
  - missing last: counter == `NUM_CLASSES`-1 with `In_Last` = 0.
- DONE state:
  - `Out_Index`, `Out_Max` and `Out_Error` hold stable while `Out_Valid` = 1 and `Out_Ready` = 0.
  - `Out_Valid` & `Out_Ready` returns the state to ACCUM.
  - No score is accepted in DONE.
- `Clear` = 1:
  - Next state = ACCUM, counter = 0, `Out_Valid` = 0, `Out_Error` = 0.
  - `Out_Index` and `Out_Max` keep their last values; they are don't-care until the next result.
  - `Clear` has priority over any handshake in the same cycle; that cycle's score is dropped.
- Counter arithmetic: `IDX_W` bits. The counter never exceeds `NUM_CLASSES`-1, so it cannot wrap.

## Timing
- `Out_Valid` rises on the cycle after the last score is accepted (result latency 1 cycle).
- Throughput with `In_Valid` and `Out_Ready` held high: one frame per `NUM_CLASSES`+1 cycles.
  - Score cycles are 0..`NUM_CLASSES`-1; cycle `NUM_CLASSES` is DONE.
  - The first score of the next frame is accepted on the cycle after the result handshake.
- `In_Ready` and `Out_Valid` are decoded from registered state, with no combinational path from `In_Valid` or `Out_Ready`.
- Reset mid-frame discards the partial frame immediately, with no output pulse.
- `Clear` takes effect at the next edge. `In_Ready` = 1 and `Out_Valid` = 0 from the following cycle.

## Test plan
- **Unsigned ordered frame.** `NUM_CLASSES` = 10, `SIGNED` = 0, scores 5,9,3,9,1,0,2,8,7,4 with `In_Last` on element 9.
  - Required: `Out_Index` = 1, `Out_Max` = 9, `Out_Error` = 0.
  - Required: `Out_Valid` high exactly 1 cycle after the 10th handshake.
- **Signed mode.** `SIGNED` = 1, `NUM_SIZE` = 8, scores 0xF0 (-16), 0x80 (-128), 0xFF (-1), then seven copies of 0xFE.
  - Required: `Out_Index` = 2, `Out_Max` = 0xFF.
  - Same stimulus with `SIGNED` = 0 -> required: `Out_Index` = 2, `Out_Max` = 0xFF, because 0xFF is also the unsigned maximum.
  - Swap element 2 to 0x7F -> required: signed `Out_Index` = 2; unsigned `Out_Index` = 0 with `Out_Max` = 0xFE... no: unsigned max is 0xFE at index 3, so required unsigned `Out_Index` = 3, `Out_Max` = 0xFE.
- **Back-pressure.** Hold `Out_Ready` = 0 for 5 cycles after `Out_Valid`, while driving `In_Valid` = 1.
  - Required: `In_Ready` = 0 throughout, outputs stable, no score consumed.
  - Raise `Out_Ready` -> required: the next frame starts 1 cycle later.
- **Early and missing In_Last.**
  - `In_Last` on element 3 of scores 1,7,2,5 -> required: `Out_Index` = 1, `Out_Max` = 7, `Out_Error` = 1.
  - Ten elements with no `In_Last` -> required: `Out_Error` = 1, with the index computed correctly.
- **Clear and reset mid-frame.** After 4 scores, pulse `Clear` together with `In_Valid` -> required: that score is dropped and the next 10 scores form a clean frame with `Out_Error` = 0.
  - Repeat using `GlobalReset` low for 1 cycle mid-frame -> required: all outputs 0 immediately and no `Out_Valid` pulse.
- **Gapped input and all-equal scores.** 10 equal scores (0x3FFFFFF) with random `In_Valid` gaps.
  - Required: `Out_Index` = 0 (lowest index wins ties), `Out_Max` = 0x3FFFFFF.
